pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its period and high time in `clk` cycles. It is the receive-side counterpart of the breathing-lamp PWM generator, used in loopback checks and to read external PWM sources such as a fan tach or a servo command. The asynchronous `pwm_in` is synchronised, then rising and falling edges are timed. A static (stuck) input is flagged after a timeout.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_capture_sync_edge.sv | 31 +++
 rtl/pwm_capture.sv | 113 +++++++++++
 tb/tb_pwm_capture.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM lamp design: capture FSM states, counter
// width/saturation, and the nominal 1 ms period shared with the generator.
package pwm_pkg;

    localparam int              CNT_W       = 16;
    localparam logic [CNT_W-1:0] CNT_SAT     = 16'hFFFF;
    localparam logic [CNT_W-1:0] MAX_1MS_DEF = 16'd50000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } cap_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchroniser plus a delay flop for edge detection of an
// asynchronous level input. Reusable for key inputs elsewhere.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // Metastability chain s1->s2, then s3 delays s2 by one cycle for edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: times rising-to-rising period and high time of pwm_in in
// clk cycles, flags a static input after TIMEOUT cycles without a rise.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter logic [CNT_W-1:0] MAX_1MS = MAX_1MS_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] duty,
    output logic             valid,
    output logic             stuck,
    output logic             in_range
);

    // Range window computed one bit wider so MAX_1MS + MAX_1MS/8 cannot wrap.
    localparam logic [CNT_W:0] LO_LIM = (CNT_W+1)'(MAX_1MS) - (CNT_W+1)'(MAX_1MS >> 3);
    localparam logic [CNT_W:0] HI_LIM = (CNT_W+1)'(MAX_1MS) + (CNT_W+1)'(MAX_1MS >> 3);

    logic             level, rise;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    cap_state_t       state_q, state_d;
    logic             meas_upd, to_stuck;

    sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  ()
    );

    // Period and high-time counters; both restart at 1 on a rise so the
    // value seen at the next rise equals the cycle count. Period holds in STUCK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
        end else begin
            if (state_q != STUCK) per_cnt <= sat_inc(per_cnt);
            if (level)            hi_cnt  <= sat_inc(hi_cnt);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and update strobes; a rise always beats a coincident timeout.
    always_comb begin
        state_d  = state_q;
        meas_upd = 1'b0;
        to_stuck = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end else if (per_cnt == TIMEOUT) begin
                    state_d  = STUCK;
                    to_stuck = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    meas_upd = 1'b1;
                end else if (per_cnt == TIMEOUT) begin
                    state_d  = STUCK;
                    to_stuck = 1'b1;
                end
            end
            STUCK: begin
                if (rise) state_d = MEASURE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers: capture on a full period, or report a stuck level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period <= '0;
            duty   <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= meas_upd | to_stuck;
            if (meas_upd) begin
                period <= per_cnt;
                duty   <= hi_cnt;
            end else if (to_stuck) begin
                period <= '0;
                duty   <= level ? CNT_SAT : '0;
            end
        end
    end

    // Range flag follows period by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_range <= 1'b0;
        else     in_range <= ({1'b0, period} >= LO_LIM) && ({1'b0, period} <= HI_LIM);
    end

    assign stuck = (state_q == STUCK);

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture, scaled down: nominal period 800 cycles,
// timeout 3000 cycles. pwm_in is driven synchronously on the falling edge.
module tb_pwm_capture;

    localparam logic [15:0] MAXP = 16'd800;
    localparam int          TO   = 3000;

    typedef struct {
        logic [15:0] per;
        logic [15:0] dut;
        logic        stk;
        logic        inr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [15:0] period, duty;
    logic        valid, stuck, in_range;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    bit          have_prev = 0;
    int          prev_hi, prev_lo;

    pwm_capture #(.MAX_1MS(MAXP), .TIMEOUT(16'(TO))) dut (
        .clk      (clk),
        .rst      (rst),
        .pwm_in   (pwm_in),
        .period   (period),
        .duty     (duty),
        .valid    (valid),
        .stuck    (stuck),
        .in_range (in_range)
    );

    always #5 clk = ~clk;

    function automatic logic exp_inr(input int p);
        return (p >= 700) && (p <= 900);
    endfunction

    task automatic push(input int p, input int d, input logic s);
        exp_t e;
        e.per = 16'(p);
        e.dut = 16'(d);
        e.stk = s;
        e.inr = exp_inr(p);
        q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One PWM period starting with a rise; the rise reports the previous period.
    task automatic pulse(input int hi, input int lo);
        if (have_prev) push(prev_hi + prev_lo, prev_hi, 1'b0);
        have_prev = 1;
        prev_hi   = hi;
        prev_lo   = lo;
        pwm_in = 1'b1;
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Monitor: pop an expectation on every valid; check in_range one cycle on.
    initial begin
        exp_t e;
        bit   chk_inr = 0;
        logic inr_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_inr && !rst) check("in_range", int'(in_range), int'(inr_exp));
            chk_inr = 0;
            if (!rst && valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("period", int'(period), int'(e.per));
                    check("duty",   int'(duty),   int'(e.dut));
                    check("stuck_at_valid", int'(stuck), int'(e.stk));
                    chk_inr = 1;
                    inr_exp = e.inr;
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period",   int'(period),   0);
        check("rst_duty",     int'(duty),     0);
        check("rst_valid",    int'(valid),    0);
        check("rst_stuck",    int'(stuck),    0);
        check("rst_in_range", int'(in_range), 0);
        rst = 1'b0;

        // Held low from reset: one timeout report.
        push(0, 0, 1'b1);
        repeat (TO + 20) @(negedge clk);
        check("stuck_low_level", int'(stuck), 1);

        // Loopback 25% duty; first rise only leaves STUCK.
        have_prev = 0;
        pulse(200, 600);
        check("stuck_cleared", int'(stuck), 0);
        repeat (3) pulse(200, 600);

        // Duty steps, then narrow pulses at a short period.
        repeat (2) pulse(500, 300);
        repeat (3) pulse(10, 790);
        repeat (3) pulse(2, 94);

        // Reset at the midpoint of a nominal period.
        pulse(200, 200);
        rst = 1'b1;
        #1;
        check("mid_rst_period",   int'(period),   0);
        check("mid_rst_duty",     int'(duty),     0);
        check("mid_rst_valid",    int'(valid),    0);
        check("mid_rst_stuck",    int'(stuck),    0);
        check("mid_rst_in_range", int'(in_range), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        have_prev = 0;
        repeat (3) pulse(200, 600);

        // Held high: previous period reported, then stuck with full duty.
        if (have_prev) push(prev_hi + prev_lo, prev_hi, 1'b0);
        have_prev = 0;
        push(0, 16'hFFFF, 1'b1);
        pwm_in = 1'b1;
        repeat (TO + 20) @(negedge clk);
        check("stuck_high_level", int'(stuck), 1);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        pulse(200, 600);
        check("stuck_high_cleared", int'(stuck), 0);
        repeat (2) pulse(300, 500);

        repeat (50) @(negedge clk);
        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
